// File: rtl/rally_sched.sv
// Ping-pong rally scheduler: serves, timed ball steps, returns, faults, misses,
// scoring and match-end detection. All outputs are registered off one FSM.
`timescale 1ns/1ps
module rally_sched #(
   parameter logic [27:0] BASE_PERIOD   = 28'd25_000_000,
   parameter logic [27:0] MIN_PERIOD    = 28'd6_000_000,
   parameter int unsigned SPEEDUP_SHIFT = 3,
   parameter logic [3:0]  WIN_SCORE     = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit_r,
   input  logic       hit_l,
   output logic [7:0] ball,
   output logic       step,
   output logic [3:0] score_r,
   output logic [3:0] score_l,
   output logic       point_pulse,
   output logic       point_winner,
   output logic       match_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TO_L  = 3'd2,
      TO_R  = 3'd3,
      POINT = 3'd4,
      OVER  = 3'd5
   } state_t;

   state_t      cur, nxt;
   logic [7:0]  ball_q, ball_d;
   logic        step_q, step_d;
   logic [3:0]  sr_q, sr_d, sl_q, sl_d;
   logic        pp_q, pp_d;
   logic        pw_q, pw_d;
   logic [27:0] period_q, period_d;
   logic [27:0] timer_q, timer_d;

   logic        expire;
   logic [27:0] faster, faster_c;
   logic        serve_r, serve_l, award, award_left;

   assign expire   = (timer_q == period_q - 28'd1);
   assign faster   = period_q - (period_q >> SPEEDUP_SHIFT);
   assign faster_c = (faster < MIN_PERIOD) ? MIN_PERIOD : faster;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur      <= IDLE;
         ball_q   <= 8'h00;
         step_q   <= 1'b0;
         sr_q     <= 4'd0;
         sl_q     <= 4'd0;
         pp_q     <= 1'b0;
         pw_q     <= 1'b0;
         period_q <= BASE_PERIOD;
         timer_q  <= 28'd0;
      end else begin
         cur      <= nxt;
         ball_q   <= ball_d;
         step_q   <= step_d;
         sr_q     <= sr_d;
         sl_q     <= sl_d;
         pp_q     <= pp_d;
         pw_q     <= pw_d;
         period_q <= period_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      nxt        = cur;
      ball_d     = ball_q;
      step_d     = 1'b0;
      sr_d       = sr_q;
      sl_d       = sl_q;
      pp_d       = 1'b0;
      pw_d       = pw_q;
      period_d   = period_q;
      timer_d    = timer_q;
      serve_r    = 1'b0;
      serve_l    = 1'b0;
      award      = 1'b0;
      award_left = 1'b0;

      case (cur)
         IDLE: begin
            serve_r = hit_r;
            serve_l = hit_l & ~hit_r;
         end
         POINT: begin
            serve_r = hit_r & ~pw_q;
            serve_l = hit_l & pw_q;
         end
         TO_L: begin
            // A click decides the edge even when the timer expires on it.
            if (hit_l) begin
               if (ball_q == 8'h80) begin
                  nxt      = TO_R;
                  timer_d  = 28'd0;
                  period_d = faster_c;
               end else begin
                  award = 1'b1;
               end
            end else if (expire) begin
               if (ball_q == 8'h80) begin
                  award = 1'b1;
               end else begin
                  timer_d = 28'd0;
                  step_d  = 1'b1;
                  ball_d  = ball_q << 1;
               end
            end else begin
               timer_d = timer_q + 28'd1;
            end
         end
         TO_R: begin
            if (hit_r) begin
               if (ball_q == 8'h01) begin
                  nxt      = TO_L;
                  timer_d  = 28'd0;
                  period_d = faster_c;
               end else begin
                  award      = 1'b1;
                  award_left = 1'b1;
               end
            end else if (expire) begin
               if (ball_q == 8'h01) begin
                  award      = 1'b1;
                  award_left = 1'b1;
               end else begin
                  timer_d = 28'd0;
                  step_d  = 1'b1;
                  ball_d  = ball_q >> 1;
               end
            end else begin
               timer_d = timer_q + 28'd1;
            end
         end
         OVER: ;
         default: nxt = IDLE;
      endcase

      if (serve_r || serve_l) begin
         ball_d   = serve_r ? 8'h01 : 8'h80;
         nxt      = serve_r ? TO_L : TO_R;
         period_d = BASE_PERIOD;
         timer_d  = 28'd0;
      end

      if (award) begin
         ball_d  = 8'h00;
         timer_d = 28'd0;
         pp_d    = 1'b1;
         pw_d    = award_left;
         if (award_left) begin
            sl_d = sl_q + 4'd1;
            nxt  = (sl_q + 4'd1 == WIN_SCORE) ? OVER : POINT;
         end else begin
            sr_d = sr_q + 4'd1;
            nxt  = (sr_q + 4'd1 == WIN_SCORE) ? OVER : POINT;
         end
      end
   end

   assign ball         = ball_q;
   assign step         = step_q;
   assign score_r      = sr_q;
   assign score_l      = sl_q;
   assign point_pulse  = pp_q;
   assign point_winner = pw_q;
   assign match_over   = (cur == OVER);
   assign state        = cur;

endmodule

// File: tb/tb_rally_sched.sv
// Self-checking bench for rally_sched: table-driven rallies plus hand-written
// corner sequences, every observation checked against a queue of expected vectors.
`timescale 1ns/1ps
module tb_rally_sched;

   localparam int W = 23;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hit_r = 1'b0;
   logic       hit_l = 1'b0;
   logic [7:0] ball;
   logic       step;
   logic [3:0] score_r, score_l;
   logic       point_pulse, point_winner, match_over;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic r;
      logic l;
      int   gap;
   } row_t;
   row_t rows[5];

   rally_sched #(
      .BASE_PERIOD  (28'd8),
      .MIN_PERIOD   (28'd4),
      .SPEEDUP_SHIFT(2),
      .WIN_SCORE    (4'd2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hit_r       (hit_r),
      .hit_l       (hit_l),
      .ball        (ball),
      .step        (step),
      .score_r     (score_r),
      .score_l     (score_l),
      .point_pulse (point_pulse),
      .point_winner(point_winner),
      .match_over  (match_over),
      .state       (state)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [7:0] b,
                                         input logic stp, input logic pp, input logic pw,
                                         input logic mo, input logic [3:0] sr,
                                         input logic [3:0] sl);
      return {st, b, stp, pp, pw, mo, sr, sl};
   endfunction

   function automatic logic [W-1:0] obs();
      return pack(state, ball, step, point_pulse, point_winner, match_over, score_r, score_l);
   endfunction

   task automatic check_int(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Vector layout: state[22:20] ball[19:12] step pulse winner over score_r score_l
   task automatic check_vec(input string name);
      logic [W-1:0] e;
      logic [W-1:0] a;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: expected queue empty", name);
         return;
      end
      e = exp_q.pop_front();
      a = obs();
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic hit(input logic r, input logic l, input logic [W-1:0] e, input string name);
      exp_q.push_back(e);
      hit_r = r;
      hit_l = l;
      @(posedge clk);
      #1;
      hit_r = 1'b0;
      hit_l = 1'b0;
      check_vec(name);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_evt(input bit want_point, input int gap, input logic [W-1:0] e,
                           input string name);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      exp_q.push_back(e);
      while (!seen && n < 64) begin
         @(posedge clk);
         #1;
         n++;
         seen = want_point ? point_pulse : step;
      end
      check_int({name, "_gap"}, seen ? n : -1, gap);
      check_vec(name);
   endtask

   task automatic run_steps(input logic [2:0] st, input logic [7:0] start, input int gap,
                            input logic [3:0] sr, input logic [3:0] sl, input logic pw,
                            input string name);
      logic [7:0] b;
      b = start;
      for (int k = 0; k < 7; k++) begin
         b = (st == 3'd2) ? (b << 1) : (b >> 1);
         wait_evt(1'b0, gap, pack(st, b, 1'b1, 1'b0, pw, 1'b0, sr, sl), name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] st;
      logic [7:0] b0;

      rows[0] = '{r: 1'b1, l: 1'b0, gap: 8};
      rows[1] = '{r: 1'b0, l: 1'b1, gap: 6};
      rows[2] = '{r: 1'b1, l: 1'b0, gap: 5};
      rows[3] = '{r: 1'b0, l: 1'b1, gap: 4};
      rows[4] = '{r: 1'b1, l: 1'b0, gap: 4};

      idle(2);
      exp_q.push_back('0);
      check_vec("reset");
      rst = 1'b0;

      // Serve, travel and speed-up to the clamp
      for (int i = 0; i < 5; i++) begin
         st = rows[i].r ? 3'd2 : 3'd3;
         b0 = rows[i].r ? 8'h01 : 8'h80;
         hit(rows[i].r, rows[i].l, pack(st, b0, 0, 0, 0, 0, 4'd0, 4'd0), "row_hit");
         run_steps(st, b0, rows[i].gap, 4'd0, 4'd0, 1'b0, "row_step");
      end

      // Miss at the left end, then only the winner may serve
      wait_evt(1'b1, 4, pack(3'd4, 8'h00, 0, 1, 0, 0, 4'd1, 4'd0), "miss");
      hit(0, 0, pack(3'd4, 8'h00, 0, 0, 0, 0, 4'd1, 4'd0), "pulse_len");
      hit(0, 1, pack(3'd4, 8'h00, 0, 0, 0, 0, 4'd1, 4'd0), "loser_ignored");
      hit(1, 0, pack(3'd2, 8'h01, 0, 0, 0, 0, 4'd1, 4'd0), "winner_serve");
      wait_evt(1'b0, 8, pack(3'd2, 8'h02, 1, 0, 0, 0, 4'd1, 4'd0), "serve_gap");
      wait_evt(1'b0, 8, pack(3'd2, 8'h04, 1, 0, 0, 0, 4'd1, 4'd0), "step04");

      // Asynchronous reset mid-rally, observed before any clock edge
      idle(2);
      rst = 1'b1;
      #1;
      exp_q.push_back('0);
      check_vec("async_rst");
      idle(1);
      rst = 1'b0;

      hit(1, 1, pack(3'd2, 8'h01, 0, 0, 0, 0, 4'd0, 4'd0), "dual_serve");
      wait_evt(1'b0, 8, pack(3'd2, 8'h02, 1, 0, 0, 0, 4'd0, 4'd0), "s02");
      wait_evt(1'b0, 8, pack(3'd2, 8'h04, 1, 0, 0, 0, 4'd0, 4'd0), "s04");
      hit(0, 1, pack(3'd4, 8'h00, 0, 1, 0, 0, 4'd1, 4'd0), "early_swing");

      // Return on the very edge the timer expires: no step, no miss
      hit(1, 0, pack(3'd2, 8'h01, 0, 0, 0, 0, 4'd1, 4'd0), "reserve");
      run_steps(3'd2, 8'h01, 8, 4'd1, 4'd0, 1'b0, "travel");
      idle(7);
      hit(0, 1, pack(3'd3, 8'h80, 0, 0, 0, 0, 4'd1, 4'd0), "hit_at_expiry");
      run_steps(3'd3, 8'h80, 6, 4'd1, 4'd0, 1'b0, "ret6");
      hit(1, 0, pack(3'd2, 8'h01, 0, 0, 0, 0, 4'd1, 4'd0), "ret_r");
      run_steps(3'd2, 8'h01, 5, 4'd1, 4'd0, 1'b0, "ret5");
      hit(1, 1, pack(3'd3, 8'h80, 0, 0, 0, 0, 4'd1, 4'd0), "dual_return");
      run_steps(3'd3, 8'h80, 4, 4'd1, 4'd0, 1'b0, "ret4");

      // Right misses; left scores and serves
      wait_evt(1'b1, 4, pack(3'd4, 8'h00, 0, 1, 1, 0, 4'd1, 4'd1), "left_scores");
      hit(1, 0, pack(3'd4, 8'h00, 0, 0, 1, 0, 4'd1, 4'd1), "right_ignored");
      hit(0, 1, pack(3'd3, 8'h80, 0, 0, 1, 0, 4'd1, 4'd1), "left_serve");
      run_steps(3'd3, 8'h80, 8, 4'd1, 4'd1, 1'b1, "lserve_step");
      hit(1, 0, pack(3'd2, 8'h01, 0, 0, 1, 0, 4'd1, 4'd1), "ret_before_end");

      // Left swings early: right reaches the winning score
      hit(0, 1, pack(3'd5, 8'h00, 0, 1, 0, 1, 4'd2, 4'd1), "match_end");
      for (int i = 0; i < 100; i++) begin
         hit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pack(3'd5, 8'h00, 0, 0, 0, 1, 4'd2, 4'd1), "over_hold");
      end

      check_int("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
